// File: rtl/gpio_input_capture.sv
// GPIO input capture: synchronised pins, sticky W1C edge latches and a masked, registered interrupt.
// Optional per-pin debounce filter when GPIO_IN_DEBOUNCE_EN is defined; otherwise the level is the last sync stage.
module gpio_input_capture #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 64
) (
  input  logic             sysClk,
  input  logic             sysReset,
  input  logic             sysCsrStrobe,
  input  logic [31:0]      sysGpioOut,
  output logic [31:0]      sysCsr,
  input  logic [WIDTH-1:0] gpioIn,
  output logic             sysInterrupt
);

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  // Edges are ignored until the pipeline has flushed its post-reset contents.
  localparam int ARM_CYCLES = SYNC_STAGES + 1 + (DB_EN ? DEBOUNCE_CYCLES : 0);
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] latch_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic [15:0]      latch_16;
  logic [15:0]      level_16;
  logic             csr_unused;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpioIn;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0]  db_cnt [WIDTH];
  logic [WIDTH-1:0] level_q;

  // Level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      level_q <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (synced[i] == level_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q[i] <= synced[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = level_q;
`else
  assign level = synced;
`endif

  assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));
  assign evt   = armed ? (prev_q ^ level) : '0;
  assign clr   = (sysCsrStrobe && !sysGpioOut[31]) ? sysGpioOut[WIDTH-1:0] : '0;

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      arm_cnt <= '0;
      prev_q  <= '0;
      latch_q <= '0;
      mask_q  <= '0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
      prev_q  <= level;
      // Set wins over a same-cycle clear so no edge is lost.
      latch_q <= (latch_q & ~clr) | evt;
      if (sysCsrStrobe && sysGpioOut[31]) mask_q <= sysGpioOut[WIDTH-1:0];
    end
  end

  always_comb begin
    latch_16              = '0;
    level_16              = '0;
    latch_16[WIDTH-1:0]   = latch_q;
    level_16[WIDTH-1:0]   = level;
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      sysCsr       <= '0;
      sysInterrupt <= 1'b0;
    end else begin
      sysCsr       <= {latch_16, level_16};
      sysInterrupt <= |(latch_q & mask_q);
    end
  end

  assign csr_unused = ^sysGpioOut[30:WIDTH];

endmodule

// File: tb/tb_gpio_input_capture.sv
// Scoreboard bench for gpio_input_capture: expectations are queued with stimulus, drained at sample points.
module tb_gpio_input_capture;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int DBL = 8;
`else
  localparam int DBL = 0;
`endif

  logic        sysClk;
  logic        sysReset;
  logic        sysCsrStrobe;
  logic [31:0] sysGpioOut;
  logic [31:0] sysCsr;
  logic [15:0] gpioIn;
  logic        sysInterrupt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    bit          is_irq;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  gpio_input_capture #(
    .WIDTH(16),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .sysClk(sysClk),
    .sysReset(sysReset),
    .sysCsrStrobe(sysCsrStrobe),
    .sysGpioOut(sysGpioOut),
    .sysCsr(sysCsr),
    .gpioIn(gpioIn),
    .sysInterrupt(sysInterrupt)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_csr(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b0; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_irq(input string tag, input logic v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b1; e.val = {31'd0, v};
    exp_q.push_back(e);
  endtask

  // Drain every pending expectation against the DUT outputs as they stand now.
  task automatic sample();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.is_irq) check(e.tag, {31'd0, sysInterrupt}, e.val);
      else          check(e.tag, sysCsr, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic csr_write(input logic [31:0] d);
    sysCsrStrobe = 1'b1;
    sysGpioOut   = d;
    tick(1);
    sysCsrStrobe = 1'b0;
    sysGpioOut   = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sysReset     = 1'b1;
    sysCsrStrobe = 1'b0;
    sysGpioOut   = 32'd0;
    gpioIn       = 16'hFFFF;
    tick(3);
    push_csr("rst_csr", 32'h0000_0000);
    push_irq("rst_irq", 1'b0);
    sample();

    // Pins already high at reset release: level visible, no latches.
    sysReset = 1'b0;
    tick(10 + DBL);
    push_csr("arm_csr", 32'h0000_FFFF);
    push_irq("arm_irq", 1'b0);
    sample();

    // All pins fall: every latch set.
    gpioIn = 16'h0000;
    tick(6 + DBL);
    push_csr("fall_csr", 32'hFFFF_0000);
    sample();
    csr_write(32'h0000_FFFF);
    tick(1);
    push_csr("clr_all", 32'h0000_0000);
    sample();

    // Rising pin 3: level after edge 3, latch after edge 4, then W1C.
    gpioIn = 16'h0008;
    tick(2 + DBL);
    push_csr("p3_e2", 32'h0000_0000);
    sample();
    tick(1);
    push_csr("p3_e3", 32'h0000_0008);
    sample();
    tick(1);
    push_csr("p3_e4", 32'h0008_0008);
    sample();
    csr_write(32'h0000_0008);
    tick(1);
    push_csr("p3_clr", 32'h0000_0008);
    sample();

    // Mask pin 0 only; interrupt follows latch by one cycle.
    csr_write(32'h8000_0001);
    gpioIn = 16'h0009;
    tick(3 + DBL);
    push_csr("p0_e3", 32'h0000_0009);
    push_irq("p0_irq_e3", 1'b0);
    sample();
    tick(1);
    push_csr("p0_e4", 32'h0001_0009);
    push_irq("p0_irq_e4", 1'b1);
    sample();
    csr_write(32'h0000_0001);
    tick(1);
    push_irq("p0_irq_clr", 1'b0);
    sample();
    gpioIn = 16'h000B;
    tick(6 + DBL);
    push_csr("p1_unmasked_csr", 32'h0002_000B);
    push_irq("p1_unmasked_irq", 1'b0);
    sample();

    // Clear of bit 5 in the same cycle as a new pin-5 edge: set wins.
    csr_write(32'h0000_FFFF);
    gpioIn = 16'h002B;
    tick(6 + DBL);
    push_csr("p5_rise", 32'h0020_002B);
    sample();
    gpioIn = 16'h000B;
    tick(2 + DBL);
    csr_write(32'h0000_0020);
    tick(1);
    push_csr("p5_set_wins", 32'h0020_000B);
    sample();

    // Latches 0x00F0 with full mask, then asynchronous reset mid-cycle.
    csr_write(32'h0000_FFFF);
    csr_write(32'h8000_FFFF);
    tick(2);
    push_csr("pre_f0_csr", 32'h0000_000B);
    push_irq("pre_f0_irq", 1'b0);
    sample();
    gpioIn = 16'h00FB;
    tick(6 + DBL);
    push_csr("f0_csr", 32'h00F0_00FB);
    push_irq("f0_irq", 1'b1);
    sample();
    #2 sysReset = 1'b1;
    #1;
    push_csr("async_rst_csr", 32'h0000_0000);
    push_irq("async_rst_irq", 1'b0);
    sample();
    tick(2);
    sysReset = 1'b0;
    tick(10 + DBL);
    push_csr("rearm_csr", 32'h0000_00FB);
    push_irq("rearm_irq", 1'b0);
    sample();

`ifdef GPIO_IN_DEBOUNCE_EN
    // Short pulse on pin 2 filtered out; a held level is accepted.
    gpioIn = 16'h00FF;
    tick(5);
    gpioIn = 16'h00FB;
    tick(20);
    push_csr("db_pulse", 32'h0000_00FB);
    sample();
    gpioIn = 16'h00FF;
    tick(10);
    push_csr("db_hold_e10", 32'h0000_00FB);
    sample();
    tick(1);
    push_csr("db_hold_e11", 32'h0000_00FF);
    sample();
    tick(1);
    push_csr("db_hold_latch", 32'h0004_00FF);
    sample();
    tick(8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
